// File: rtl/vp_validate_queue_pkg.sv
// Shared types and defaults for the value-prediction validation queue.
// One entry holds what the predictor claimed until the real result retires.
package vp_pkg;

  localparam int VP_NUM_PRED    = 2;
  localparam int VP_QUEUE_DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        conf;
  } vp_entry_t;

endpackage

// File: rtl/vp_validate_queue_if.sv
// Predictor/core side bundle of the validation queue.
// master = predictor and retire stage, slave = the queue itself.
interface vp_validate_queue_if #(
  parameter int P_NUM_PRED  = vp_pkg::VP_NUM_PRED,
  parameter int P_CNT_WIDTH = $clog2(vp_pkg::VP_QUEUE_DEPTH) + 1
);

  logic [P_NUM_PRED-1:0][31:0] pred_pc_i;
  logic [P_NUM_PRED-1:0][31:0] pred_result_i;
  logic [P_NUM_PRED-1:0]       pred_conf_i;
  logic [P_NUM_PRED-1:0]       pred_valid_i;
  logic [P_NUM_PRED-1:0][31:0] exe_actual_i;
  logic [P_NUM_PRED-1:0]       exe_valid_i;
  logic                        flush_i;
  logic [P_NUM_PRED-1:0][31:0] fb_pc_o;
  logic [P_NUM_PRED-1:0][31:0] fb_actual_o;
  logic [P_NUM_PRED-1:0]       fb_mispredict_o;
  logic [P_NUM_PRED-1:0]       fb_conf_o;
  logic [P_NUM_PRED-1:0]       fb_valid_o;
  logic                        full_o;
  logic [P_CNT_WIDTH-1:0]      count_o;
  logic                        overflow_o;
  logic                        underflow_o;

  modport master (
    output pred_pc_i, pred_result_i, pred_conf_i, pred_valid_i,
    output exe_actual_i, exe_valid_i, flush_i,
    input  fb_pc_o, fb_actual_o, fb_mispredict_o, fb_conf_o,
    input  fb_valid_o, full_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  pred_pc_i, pred_result_i, pred_conf_i, pred_valid_i,
    input  exe_actual_i, exe_valid_i, flush_i,
    output fb_pc_o, fb_actual_o, fb_mispredict_o, fb_conf_o,
    output fb_valid_o, full_o, count_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/vp_circ_buf.sv
// Multi-port circular storage: compacted write at tail, read at head+offset.
// Storage is not reset; pointers in the owner define which slots are live.
module vp_circ_buf #(
  parameter int  P_DEPTH = 16,
  parameter type T       = logic,
  parameter int  P_PORTS = 2,
  localparam int AW      = $clog2(P_DEPTH)
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [P_PORTS-1:0] wr_valid_i,
  input  T                   wr_data_i [P_PORTS],
  input  logic [AW-1:0]      wr_ptr_i,
  input  logic [AW-1:0]      rd_ptr_i,
  output T                   rd_data_o [P_PORTS]
);

  T              mem_q [P_DEPTH];
  T              mem_d [P_DEPTH];
  logic [AW-1:0] slot;

  // Only valid lanes take a slot, so a sparse group still lands contiguously.
  always_comb begin
    mem_d = mem_q;
    slot  = wr_ptr_i;
    for (int p = 0; p < P_PORTS; p++) begin
      if (wr_en_i && wr_valid_i[p]) begin
        mem_d[slot] = wr_data_i[p];
        slot        = slot + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    for (int p = 0; p < P_PORTS; p++) begin
      rd_data_o[p] = mem_q[rd_ptr_i + AW'(p)];
    end
  end

endmodule

// File: rtl/vp_validate_queue.sv
// In-order validation queue between the value predictor and retire.
// Holds predictions, compares them with retired values, drives feedback.
module vp_validate_queue
  import vp_pkg::*;
#(
  parameter int P_NUM_PRED    = VP_NUM_PRED,
  parameter int P_QUEUE_DEPTH = VP_QUEUE_DEPTH
) (
  input logic                clk_i,
  input logic                rst_ni,
  vp_validate_queue_if.slave bus
);

  localparam int P_CNT_WIDTH = $clog2(P_QUEUE_DEPTH) + 1;
  localparam int AW          = $clog2(P_QUEUE_DEPTH);
  localparam logic [P_CNT_WIDTH-1:0] DEPTH_C =
    P_CNT_WIDTH'(P_QUEUE_DEPTH);
  localparam logic [P_CNT_WIDTH-1:0] LANES_C =
    P_CNT_WIDTH'(P_NUM_PRED);

  logic [AW-1:0]          head_q, head_d;
  logic [AW-1:0]          tail_q, tail_d;
  logic [P_CNT_WIDTH-1:0] count_q, count_d;
  logic                   full_q, full_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  logic [P_NUM_PRED-1:0]       fb_valid_q, fb_valid_d;
  logic [P_NUM_PRED-1:0][31:0] fb_pc_q, fb_pc_d;
  logic [P_NUM_PRED-1:0][31:0] fb_act_q, fb_act_d;
  logic [P_NUM_PRED-1:0]       fb_mis_q, fb_mis_d;
  logic [P_NUM_PRED-1:0]       fb_conf_q, fb_conf_d;

  logic [P_CNT_WIDTH-1:0] enq_n, enq_eff, deq_n, free_n;
  logic                   enq_ok;
  vp_entry_t              sel;
  vp_entry_t              wr_data [P_NUM_PRED];
  vp_entry_t              rd_data [P_NUM_PRED];

  always_comb begin
    for (int p = 0; p < P_NUM_PRED; p++) begin
      wr_data[p] = '{pc:     bus.pred_pc_i[p],
                     result: bus.pred_result_i[p],
                     conf:   bus.pred_conf_i[p]};
    end
  end

  vp_circ_buf #(
    .P_DEPTH (P_QUEUE_DEPTH),
    .T       (vp_entry_t),
    .P_PORTS (P_NUM_PRED)
  ) u_buf (
    .clk_i      (clk_i),
    .wr_en_i    (enq_ok),
    .wr_valid_i (bus.pred_valid_i),
    .wr_data_i  (wr_data),
    .wr_ptr_i   (tail_q),
    .rd_ptr_i   (head_q),
    .rd_data_o  (rd_data)
  );

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    fb_valid_d = '0;
    fb_pc_d    = fb_pc_q;
    fb_act_d   = fb_act_q;
    fb_mis_d   = fb_mis_q;
    fb_conf_d  = fb_conf_q;
    enq_n      = '0;
    enq_eff    = '0;
    deq_n      = '0;
    enq_ok     = 1'b0;
    sel        = '0;
    for (int p = 0; p < P_NUM_PRED; p++) begin
      enq_n = enq_n + P_CNT_WIDTH'(bus.pred_valid_i[p]);
    end
    free_n = DEPTH_C - count_q;
    if (bus.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Retire lanes draw from entries present at cycle start only.
      for (int p = 0; p < P_NUM_PRED; p++) begin
        if (bus.exe_valid_i[p]) begin
          if (deq_n < count_q) begin
            sel = '0;
            for (int k = 0; k < P_NUM_PRED; k++) begin
              if (deq_n == P_CNT_WIDTH'(k)) begin
                sel = rd_data[k];
              end
            end
            fb_valid_d[p] = 1'b1;
            fb_pc_d[p]    = sel.pc;
            fb_act_d[p]   = bus.exe_actual_i[p];
            fb_mis_d[p]   = sel.result != bus.exe_actual_i[p];
            fb_conf_d[p]  = sel.conf;
            deq_n         = deq_n + P_CNT_WIDTH'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
      end
      enq_ok = enq_n <= free_n;
      if (!enq_ok) begin
        ovf_d = 1'b1;
      end
      enq_eff = enq_ok ? enq_n : '0;
      tail_d  = tail_q + enq_eff[AW-1:0];
      head_d  = head_q + deq_n[AW-1:0];
      count_d = count_q + enq_eff - deq_n;
    end
    full_d = (DEPTH_C - count_d) < LANES_C;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      fb_valid_q <= '0;
      fb_pc_q    <= '0;
      fb_act_q   <= '0;
      fb_mis_q   <= '0;
      fb_conf_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      fb_valid_q <= fb_valid_d;
      fb_pc_q    <= fb_pc_d;
      fb_act_q   <= fb_act_d;
      fb_mis_q   <= fb_mis_d;
      fb_conf_q  <= fb_conf_d;
    end
  end

  assign bus.fb_pc_o         = fb_pc_q;
  assign bus.fb_actual_o     = fb_act_q;
  assign bus.fb_mispredict_o = fb_mis_q;
  assign bus.fb_conf_o       = fb_conf_q;
  assign bus.fb_valid_o      = fb_valid_q;
  assign bus.full_o          = full_q;
  assign bus.count_o         = count_q;
  assign bus.overflow_o      = ovf_q;
  assign bus.underflow_o     = unf_q;

endmodule

// File: tb/tb_vp_validate_queue.sv
// Scoreboard bench for vp_validate_queue: queue-level reference model,
// directed corner cases then random traffic.
module tb_vp_validate_queue;

  localparam int NP    = 2;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    logic        conf;
  } m_ent_t;

  typedef struct {
    int          lane;
    logic [31:0] pc;
    logic [31:0] act;
    logic        mis;
    logic        conf;
  } fb_t;

  logic clk;
  logic rst_ni;

  vp_validate_queue_if #(.P_NUM_PRED(NP), .P_CNT_WIDTH(CW)) bus ();

  vp_validate_queue #(
    .P_NUM_PRED    (NP),
    .P_QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  m_ent_t mq[$];
  fb_t    sb[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 0;
  bit     m_ovf = 0, m_unf = 0;
  int     exp_count = 0;
  bit     exp_full = 0, exp_ovf = 0, exp_unf = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    fb_t e;
    if (rst_ni && mon_en) begin
      for (int p = 0; p < NP; p++) begin
        if (bus.fb_valid_o[p]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL fb_unexpected lane %0d pc=%0h", p,
                     bus.fb_pc_o[p]);
          end else begin
            e = sb.pop_front();
            if (e.lane != p || bus.fb_pc_o[p] !== e.pc ||
                bus.fb_actual_o[p] !== e.act ||
                bus.fb_mispredict_o[p] !== e.mis ||
                bus.fb_conf_o[p] !== e.conf) begin
              errors++;
              $display("FAIL fb lane %0d: got pc=%0h act=%0h mis=%b conf=%b want lane %0d pc=%0h act=%0h mis=%b conf=%b",
                       p, bus.fb_pc_o[p], bus.fb_actual_o[p],
                       bus.fb_mispredict_o[p], bus.fb_conf_o[p],
                       e.lane, e.pc, e.act, e.mis, e.conf);
            end
          end
        end
      end
      chk("mon_count", 32'(bus.count_o), 32'(exp_count));
      chk("mon_full", 32'(bus.full_o), 32'(exp_full));
      chk("mon_overflow", 32'(bus.overflow_o), 32'(exp_ovf));
      chk("mon_underflow", 32'(bus.underflow_o), 32'(exp_unf));
    end
  end

  task automatic idle_inputs();
    bus.pred_valid_i  = '0;
    bus.pred_pc_i     = '0;
    bus.pred_result_i = '0;
    bus.pred_conf_i   = '0;
    bus.exe_valid_i   = '0;
    bus.exe_actual_i  = '0;
    bus.flush_i       = 1'b0;
  endtask

  // Drive one cycle; the model decides what the queue must do with it.
  task automatic step(input logic [1:0] pv,
                      input logic [31:0] pc0, input logic [31:0] pc1,
                      input logic [31:0] r0, input logic [31:0] r1,
                      input logic [1:0] cf, input logic [1:0] ev,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic fl);
    logic [31:0] pcs[2];
    logic [31:0] rs[2];
    logic [31:0] as[2];
    m_ent_t e;
    fb_t    f;
    int     n, sz;
    pcs[0] = pc0; pcs[1] = pc1;
    rs[0]  = r0;  rs[1]  = r1;
    as[0]  = a0;  as[1]  = a1;
    bus.pred_valid_i  = pv;
    bus.exe_valid_i   = ev;
    bus.flush_i       = fl;
    bus.pred_conf_i   = cf;
    for (int p = 0; p < NP; p++) begin
      bus.pred_pc_i[p]     = pcs[p];
      bus.pred_result_i[p] = rs[p];
      bus.exe_actual_i[p]  = as[p];
    end
    n  = int'(pv[0]) + int'(pv[1]);
    sz = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (ev[p]) begin
          if (mq.size() > 0) begin
            e = mq.pop_front();
            f.lane = p;
            f.pc   = e.pc;
            f.act  = as[p];
            f.mis  = (e.res != as[p]);
            f.conf = e.conf;
            sb.push_back(f);
          end else begin
            m_unf = 1;
          end
        end
      end
      if (n > DEPTH - sz) begin
        m_ovf = 1;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (pv[p]) begin
            e.pc = pcs[p]; e.res = rs[p]; e.conf = cf[p];
            mq.push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    exp_count = mq.size();
    exp_full  = (DEPTH - mq.size()) < NP;
    exp_ovf   = m_ovf;
    exp_unf   = m_unf;
    idle_inputs();
  endtask

  task automatic enq2(input logic [31:0] base);
    step(2'b11, base, base + 4, base ^ 32'h55, base ^ 32'h66, 2'b10,
         2'b00, 0, 0, 1'b0);
  endtask

  // Retire two, lane 0 matching and lane 1 mispredicting.
  task automatic drain2();
    logic [31:0] a0, a1;
    a0 = (mq.size() > 0) ? mq[0].res : 32'h0;
    a1 = (mq.size() > 1) ? (mq[1].res ^ 32'h1) : 32'h0;
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b11, a0, a1, 1'b0);
  endtask

  initial begin
    logic [1:0]  pv, ev, cf;
    logic [31:0] as[2];
    int          idx;
    rst_ni = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_fb_valid", 32'(bus.fb_valid_o), 0);
    chk("rst_full", 32'(bus.full_o), 0);
    chk("rst_flags", {bus.overflow_o, bus.underflow_o}, 0);
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    step(2'b01, 32'h100, 0, 32'h5, 0, 2'b01, 2'b00, 0, 0, 1'b0);
    chk("basic_count", 32'(bus.count_o), 1);
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 32'h5, 0, 1'b0);
    chk("basic_fb_valid", 32'(bus.fb_valid_o), 32'h1);
    chk("basic_fb_pc", bus.fb_pc_o[0], 32'h100);
    chk("basic_fb_mis", 32'(bus.fb_mispredict_o[0]), 0);
    chk("basic_fb_conf", 32'(bus.fb_conf_o[0]), 1);

    step(2'b11, 32'h200, 32'h204, 32'hA, 32'hB, 2'b00, 2'b00, 0, 0,
         1'b0);
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 32'hA, 32'hC, 1'b0);
    chk("dual_fb_valid", 32'(bus.fb_valid_o), 32'h3);
    chk("dual_fb_mis", 32'(bus.fb_mispredict_o), 32'h2);
    chk("dual_fb_pc0", bus.fb_pc_o[0], 32'h200);
    chk("dual_fb_pc1", bus.fb_pc_o[1], 32'h204);

    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 32'h7, 0, 1'b0);
    chk("unf_fb_valid", 32'(bus.fb_valid_o), 0);
    chk("unf_flag", 32'(bus.underflow_o), 1);
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1'b0);
    chk("unf_sticky", 32'(bus.underflow_o), 1);

    for (int i = 0; i < 7; i++) enq2(32'h1000 + 32'(i) * 8);
    chk("full_at14_count", 32'(bus.count_o), 14);
    chk("full_at14", 32'(bus.full_o), 0);
    step(2'b10, 0, 32'h1070, 0, 32'h77, 2'b10, 2'b00, 0, 0, 1'b0);
    chk("full_at15", 32'(bus.full_o), 1);
    enq2(32'h2000);
    chk("ovf_flag", 32'(bus.overflow_o), 1);
    chk("ovf_count", 32'(bus.count_o), 15);
    drain2();
    drain2();
    enq2(32'h3000);
    enq2(32'h3010);
    chk("wrap_count", 32'(bus.count_o), 15);
    for (int i = 0; i < 7; i++) drain2();
    drain2();
    chk("last_one_fb_valid", 32'(bus.fb_valid_o), 32'h1);
    chk("last_one_count", 32'(bus.count_o), 0);

    enq2(32'h4000);
    step(2'b01, 32'h4008, 0, 32'h9, 0, 2'b01, 2'b00, 0, 0, 1'b0);
    chk("pre_flush_count", 32'(bus.count_o), 3);
    step(2'b11, 32'h5000, 32'h5004, 1, 2, 2'b11, 2'b01, 32'h4055, 0,
         1'b1);
    chk("flush_count", 32'(bus.count_o), 0);
    chk("flush_fb_valid", 32'(bus.fb_valid_o), 0);

    enq2(32'h6000);
    step(2'b01, 32'h6010, 0, 32'h1, 0, 2'b01, 2'b01, 32'h6055, 0, 1'b0);
    rst_ni = 1'b0;
    mon_en = 0;
    #1;
    chk("midrst_fb_valid", 32'(bus.fb_valid_o), 0);
    chk("midrst_count", 32'(bus.count_o), 0);
    chk("midrst_full", 32'(bus.full_o), 0);
    chk("midrst_flags", {bus.overflow_o, bus.underflow_o}, 0);
    mq.delete();
    sb.delete();
    m_ovf = 0; m_unf = 0;
    exp_count = 0; exp_full = 0; exp_ovf = 0; exp_unf = 0;
    @(posedge clk);
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;
    chk("post_rst_count", 32'(bus.count_o), 0);
    chk("post_rst_fb_valid", 32'(bus.fb_valid_o), 0);

    for (int c = 0; c < 600; c++) begin
      pv = 2'($urandom_range(0, 3));
      cf = 2'($urandom_range(0, 3));
      ev = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      idx = 0;
      for (int p = 0; p < NP; p++) begin
        as[p] = $urandom;
        if (ev[p] && idx < mq.size()) begin
          if ($urandom_range(0, 1) == 1) as[p] = mq[idx].res;
          idx++;
        end
      end
      step(pv, $urandom, $urandom, $urandom_range(0, 7),
           $urandom_range(0, 7), cf, ev, as[0], as[1],
           ($urandom_range(0, 40) == 0));
    end
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1'b0);
    step(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
